// File: rtl/io1bit_pkg.sv
// Shared constants and FSM state type for the 1-bit IO tile control stage.
// Optional edge counter is selected by IO1BIT_CTRL_EDGE_CNT_EN (see io1bit_ctrl).
package io1bit_pkg;

  localparam logic [7:0] REG_MODE    = 8'd0;
  localparam logic [7:0] REG_EDGECNT = 8'd1;

  localparam int MODE_BIT   = 0;
  localparam int BYPASS_BIT = 1;

  typedef enum logic [1:0] {
    S_LO     = 2'd0,
    S_CHK_HI = 2'd1,
    S_HI     = 2'd2,
    S_CHK_LO = 2'd3
  } state_t;

  // A check state still reports the level that was last committed.
  function automatic logic state_level(state_t st);
    return (st == S_HI) || (st == S_CHK_LO);
  endfunction

endpackage

// File: rtl/io1bit_debounce.sv
// Pad-input conditioning: synchronizer chain, debounce FSM and edge pulses.
// In bypass the FSM tracks the synchronized level so leaving bypass is glitch-free.
module io1bit_debounce
  import io1bit_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic bypass,
  input  logic p2f,
  output logic out_level,
  output logic out_rise,
  output logic out_fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  state_t                 state_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic                   s;
  logic                   lvl_src;

  assign s       = sync_reg[SYNC_STAGES-1];
  assign lvl_src = bypass ? s : state_level(state_reg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], p2f};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_LO;
      cnt_reg   <= '0;
      out_level <= 1'b0;
      out_rise  <= 1'b0;
      out_fall  <= 1'b0;
    end else begin
      out_level <= lvl_src;
      out_rise  <= lvl_src & ~out_level;
      out_fall  <= ~lvl_src & out_level;
      if (bypass) begin
        state_reg <= s ? S_HI : S_LO;
        cnt_reg   <= '0;
      end else begin
        case (state_reg)
          S_LO: begin
            if (s) begin
              state_reg <= S_CHK_HI;
              cnt_reg   <= CNT_W'(1);
            end
          end
          S_CHK_HI: begin
            if (!s) begin
              state_reg <= S_LO;
              cnt_reg   <= '0;
            end else if (cnt_reg >= CNT_LAST) begin
              state_reg <= S_HI;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
          S_HI: begin
            if (!s) begin
              state_reg <= S_CHK_LO;
              cnt_reg   <= CNT_W'(1);
            end
          end
          default: begin
            if (s) begin
              state_reg <= S_HI;
              cnt_reg   <= '0;
            end else if (cnt_reg >= CNT_LAST) begin
              state_reg <= S_LO;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/io1bit_ctrl.sv
// IO tile control: config decode, registered f2p drive and conditioned pad input.
// Define IO1BIT_CTRL_EDGE_CNT_EN to add a rise counter readable at select 1.
module io1bit_ctrl
  import io1bit_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        config_en,
  input  logic [31:0] config_addr,
  input  logic [31:0] config_data,
  input  logic [15:0] tile_id,
  output logic [31:0] read_data,
  input  logic        in_from_fabric,
  output logic        out_to_fabric,
  output logic        out_rise,
  output logic        out_fall,
  input  logic        p2f,
  output logic        f2p,
  output logic        mode
);

  logic        hit;
  logic [7:0]  sel;
  logic        mode_reg;
  logic        bypass_reg;
  logic [31:0] rd_next;
  logic        unused_cfg;

  assign hit        = (config_addr[15:0] == tile_id);
  assign sel        = config_addr[23:16];
  assign mode       = mode_reg;
  assign unused_cfg = ^{config_addr[31:24], config_data[31:2]};

`ifdef IO1BIT_CTRL_EDGE_CNT_EN
  logic [15:0] edge_cnt_reg;

  // Clear beats a same-cycle increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_cnt_reg <= '0;
    end else if (config_en && hit && (sel == REG_EDGECNT)) begin
      edge_cnt_reg <= '0;
    end else if (out_rise && (edge_cnt_reg != 16'hFFFF)) begin
      edge_cnt_reg <= edge_cnt_reg + 16'd1;
    end
  end
`endif

  always_comb begin
    rd_next = 32'd0;
    if (hit && (sel == REG_MODE)) begin
      rd_next = {30'b0, bypass_reg, mode_reg};
    end
`ifdef IO1BIT_CTRL_EDGE_CNT_EN
    else if (hit && (sel == REG_EDGECNT)) begin
      rd_next = {16'b0, edge_cnt_reg};
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_reg   <= 1'b0;
      bypass_reg <= 1'b0;
      f2p        <= 1'b0;
      read_data  <= 32'd0;
    end else begin
      if (config_en && hit && (sel == REG_MODE)) begin
        mode_reg   <= config_data[MODE_BIT];
        bypass_reg <= config_data[BYPASS_BIT];
      end
      f2p       <= mode_reg & in_from_fabric;
      read_data <= rd_next;
    end
  end

  io1bit_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debounce (
    .clk       (clk),
    .reset     (reset),
    .bypass    (bypass_reg),
    .p2f       (p2f),
    .out_level (out_to_fabric),
    .out_rise  (out_rise),
    .out_fall  (out_fall)
  );

endmodule

// File: tb/tb_io1bit_ctrl.sv
// Scoreboard bench for io1bit_ctrl: stimulus queues expected values per cycle,
// a monitor checks them 1 time unit after each rising edge.
module tb_io1bit_ctrl;

  localparam int SIG_RD   = 0;
  localparam int SIG_MODE = 1;
  localparam int SIG_F2P  = 2;
  localparam int SIG_OUT  = 3;
  localparam int SIG_RISE = 4;
  localparam int SIG_FALL = 5;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
    string       nm;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        config_en;
  logic [31:0] config_addr;
  logic [31:0] config_data;
  logic [15:0] tile_id;
  logic [31:0] read_data;
  logic        in_from_fabric;
  logic        out_to_fabric;
  logic        out_rise;
  logic        out_fall;
  logic        p2f;
  logic        f2p;
  logic        mode;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  io1bit_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .config_en      (config_en),
    .config_addr    (config_addr),
    .config_data    (config_data),
    .tile_id        (tile_id),
    .read_data      (read_data),
    .in_from_fabric (in_from_fabric),
    .out_to_fabric  (out_to_fabric),
    .out_rise       (out_rise),
    .out_fall       (out_fall),
    .p2f            (p2f),
    .f2p            (f2p),
    .mode           (mode)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sample(int sig);
    case (sig)
      SIG_RD:   return read_data;
      SIG_MODE: return {31'b0, mode};
      SIG_F2P:  return {31'b0, f2p};
      SIG_OUT:  return {31'b0, out_to_fabric};
      SIG_RISE: return {31'b0, out_rise};
      default:  return {31'b0, out_fall};
    endcase
  endfunction

  task automatic push_exp(int dly, int sig, logic [31:0] v, string nm);
    exp_t e;
    e.cyc = cyc + dly;
    e.sig = sig;
    e.val = v;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  task automatic nclk(int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: check every expectation that falls due on this edge.
  always begin
    logic [31:0] act;
    @(posedge clk);
    #1;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        checks++;
        act = sample(sb[i].sig);
        if (act !== sb[i].val) begin
          failures++;
          $display("FAIL %s cyc=%0d got=%h expected=%h", sb[i].nm, cyc, act, sb[i].val);
        end
        $display("check %s cyc=%0d got=%h", sb[i].nm, cyc, act);
        sb.delete(i);
      end
    end
  end

  initial begin
    logic pat [4];
    pat = '{1'b0, 1'b1, 1'b1, 1'b0};

    reset = 1'b1;
    config_en = 1'b0;
    config_addr = 32'h0;
    config_data = 32'h0;
    tile_id = 16'd5;
    in_from_fabric = 1'b0;
    p2f = 1'b0;
    nclk(3);
    reset = 1'b0;
    push_exp(1, SIG_RD,   32'd0, "rst_rd");
    push_exp(1, SIG_MODE, 32'd0, "rst_mode");
    push_exp(1, SIG_F2P,  32'd0, "rst_f2p");
    push_exp(1, SIG_OUT,  32'd0, "rst_out");
    push_exp(1, SIG_RISE, 32'd0, "rst_rise");
    push_exp(1, SIG_FALL, 32'd0, "rst_fall");
    nclk(1);

    // Write with a foreign tile id, then with an unused select.
    tile_id = 16'd6; config_en = 1'b1; config_addr = 32'h0000_0005; config_data = 32'd1;
    push_exp(1, SIG_MODE, 32'd0, "miss_tile_mode");
    push_exp(1, SIG_RD,   32'd0, "miss_tile_rd");
    nclk(1);
    tile_id = 16'd5; config_addr = 32'h0002_0005;
    push_exp(1, SIG_MODE, 32'd0, "miss_sel_mode");
    push_exp(1, SIG_RD,   32'd0, "miss_sel_rd");
    nclk(1);

    config_addr = 32'h0000_0005; config_data = 32'd1;
    push_exp(1, SIG_MODE, 32'd1, "wr_mode");
    push_exp(1, SIG_RD,   32'd0, "wr_rd_old");
    nclk(1);
    config_en = 1'b0;
    push_exp(1, SIG_RD, 32'd1, "rd_reg0");
    nclk(1);

    for (int i = 0; i < 4; i++) begin
      in_from_fabric = pat[i];
      push_exp(1, SIG_F2P, {31'b0, pat[i]}, "f2p_follow");
      nclk(1);
    end
    in_from_fabric = 1'b1; config_en = 1'b1; config_data = 32'd0;
    push_exp(1, SIG_F2P,  32'd1, "f2p_before_clr");
    push_exp(1, SIG_MODE, 32'd0, "mode_clr");
    push_exp(2, SIG_F2P,  32'd0, "f2p_mode_clr");
    nclk(1);
    config_en = 1'b0;
    nclk(2);

    // Debounced rise and fall, 7 cycles after the pad edge.
    p2f = 1'b1;
    push_exp(6, SIG_OUT,  32'd0, "db_out_pre");
    push_exp(7, SIG_OUT,  32'd1, "db_out_rise");
    push_exp(6, SIG_RISE, 32'd0, "db_rise_pre");
    push_exp(7, SIG_RISE, 32'd1, "db_rise");
    push_exp(8, SIG_RISE, 32'd0, "db_rise_end");
    push_exp(7, SIG_FALL, 32'd0, "db_nofall");
    nclk(10);
    p2f = 1'b0;
    push_exp(6, SIG_OUT,  32'd1, "db_out_hold");
    push_exp(7, SIG_OUT,  32'd0, "db_out_fall");
    push_exp(7, SIG_FALL, 32'd1, "db_fall");
    push_exp(8, SIG_FALL, 32'd0, "db_fall_end");
    push_exp(7, SIG_RISE, 32'd0, "db_norise");
    nclk(10);

    // A 3-cycle glitch must be rejected.
    p2f = 1'b1;
    for (int d = 5; d <= 12; d++) begin
      push_exp(d, SIG_OUT,  32'd0, "glitch_out");
      push_exp(d, SIG_RISE, 32'd0, "glitch_rise");
    end
    nclk(3);
    p2f = 1'b0;
    nclk(10);

    // Bypass: 3-cycle latency, then leave bypass with the pad held high.
    config_en = 1'b1; config_data = 32'd2;
    nclk(1);
    config_en = 1'b0;
    push_exp(1, SIG_RD, 32'd2, "rd_bypass");
    nclk(1);
    p2f = 1'b1;
    push_exp(2, SIG_OUT,  32'd0, "byp_out_pre");
    push_exp(3, SIG_OUT,  32'd1, "byp_out");
    push_exp(3, SIG_RISE, 32'd1, "byp_rise");
    push_exp(4, SIG_RISE, 32'd0, "byp_rise_end");
    nclk(6);
    config_en = 1'b1; config_data = 32'd0;
    for (int d = 1; d <= 8; d++) begin
      push_exp(d, SIG_OUT,  32'd1, "byp_clr_out");
      push_exp(d, SIG_RISE, 32'd0, "byp_clr_rise");
      push_exp(d, SIG_FALL, 32'd0, "byp_clr_fall");
    end
    nclk(1);
    config_en = 1'b0;
    nclk(9);
    p2f = 1'b0;
    push_exp(7, SIG_FALL, 32'd1, "post_byp_fall");
    nclk(10);

    // Reset while the FSM is checking a rising level.
    p2f = 1'b1;
    nclk(4);
    reset = 1'b1; p2f = 1'b0;
    push_exp(1, SIG_OUT, 32'd0, "rst_mid_out");
    nclk(2);
    reset = 1'b0;
    for (int d = 1; d <= 9; d++) begin
      push_exp(d, SIG_OUT,  32'd0, "rst_rel_out");
      push_exp(d, SIG_RISE, 32'd0, "rst_rel_rise");
    end
    push_exp(1, SIG_MODE, 32'd0, "rst_rel_mode");
    nclk(10);

`ifdef IO1BIT_CTRL_EDGE_CNT_EN
    repeat (3) begin
      p2f = 1'b1;
      nclk(10);
      p2f = 1'b0;
      nclk(10);
    end
    config_addr = 32'h0001_0005;
    push_exp(1, SIG_RD, 32'd3, "edgecnt_rd");
    nclk(1);
    config_en = 1'b1;
    push_exp(1, SIG_RD, 32'd3, "edgecnt_rd_at_clr");
    nclk(1);
    config_en = 1'b0;
    push_exp(1, SIG_RD, 32'd0, "edgecnt_cleared");
    nclk(1);
`else
    p2f = 1'b1;
    nclk(10);
    p2f = 1'b0;
    nclk(10);
    config_addr = 32'h0001_0005;
    push_exp(1, SIG_RD, 32'd0, "sel1_rd_zero");
    nclk(1);
`endif
    config_addr = 32'h0000_0005;
    nclk(5);

    checks++;
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
      failures++;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
